// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues imem reads, queues returned words in order. gnt->instr_valid in 2 cycles;
// requests are credit-limited by queue space plus in-flight reads, so a stalled decode stops fetching.

module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head_dat,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_vld) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      cnt_d = cnt_q + {{AW{1'b0}}, push_vld} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] QD_W = (CW+1)'(QDEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] outstanding, q_count;
  logic          tag_empty, q_empty;
  logic [31:0]   tag_head;
  logic [63:0]   q_head;
  logic [CW:0]   used;
  logic          rsp, gnt_acc, redir_eff, q_push, q_pop;

  // The tag FIFO's occupancy is the outstanding-request count; dropped responses still pop it.
  fetch_fifo #(.W(32), .DEPTH(QDEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (1'b0),
    .push_vld (gnt_acc),
    .push_dat (fetch_pc_q),
    .pop      (rsp),
    .head_dat (tag_head),
    .empty    (tag_empty),
    .count    (outstanding)
  );

  fetch_fifo #(.W(64), .DEPTH(QDEPTH)) u_instr_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redir_eff),
    .push_vld (q_push),
    .push_dat ({imem_rdata, tag_head}),
    .pop      (q_pop),
    .head_dat (q_head),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign used      = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req  = (state_q == RUN) && (used < QD_W) && !redirect;
  assign imem_addr = fetch_pc_q;
  assign gnt_acc   = imem_req && imem_gnt;
  assign rsp       = imem_rvalid && !tag_empty;
  assign redir_eff = redirect && (state_q != BOOT);
  assign q_push    = rsp && (discard_q == '0) && !redir_eff;
  assign q_pop     = instr_valid && instr_ready && !redir_eff;

  assign instr_valid = !q_empty;
  assign instr       = instr_valid ? q_head[63:32] : NOP_INSTR;
  assign instr_pc    = instr_valid ? q_head[31:0]  : 32'h0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (gnt_acc) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // No request can be granted in a redirect cycle, so everything in flight is wrong-path.
    if (redir_eff) begin
      discard_d = outstanding - {{(CW-1){1'b0}}, rsp};
    end else if (rsp && (discard_q != '0)) begin
      discard_d = discard_q - {{(CW-1){1'b0}}, 1'b1};
    end

    case (state_q)
      BOOT:    state_d = RUN;
      RUN,
      FLUSH: begin
        if (redir_eff) begin
          state_d = (discard_d != '0) ? FLUSH : RUN;
        end else if ((state_q == FLUSH) && (discard_d == '0)) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model, expected instructions queued at response time and
// compared when decode pops them.

module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect, instr_valid, instr_ready;
  logic [31:0] redirect_pc, instr, instr_pc;

  fetch_unit #(.RESET_PC(32'h0), .QDEPTH(2), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit drop; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

  pend_t       pend[$];
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_gnt = 0;
  int          n_pop = 0;
  bit          gnt_en, rsp_en, ok;
  logic [31:0] exp_pc;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // One clock: sample at negedge, advance the model, drive memory inputs just after posedge.
  task automatic cycle();
    pend_t p;
    exp_t  e;
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_pc    = instr_pc;
    if (imem_req) chk("imem_addr", imem_addr, exp_pc);
    if (redirect) chk("req_in_redirect", {31'b0, imem_req}, 32'h0);
    if (!instr_valid) chk("nop_when_idle", instr, NOP);
    if (instr_valid && instr_ready && !redirect) begin
      n_pop++;
      if (sb.size() == 0) begin
        chk("unexpected_pop", instr_pc, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("instr_pc", instr_pc, e.pc);
        chk("instr", instr, e.ins);
      end
    end
    if (imem_rvalid) begin
      p = pend.pop_front();
      if (!p.drop && !redirect) sb.push_back('{p.addr, mem_word(p.addr)});
    end
    if (redirect) begin
      foreach (pend[i]) pend[i].drop = 1'b1;
      sb.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
    if (imem_req && imem_gnt) begin
      pend.push_back('{exp_pc, 1'b0});
      exp_pc = exp_pc + 32'd4;
      n_gnt++;
    end
    @(posedge clk);
    #1;
    imem_gnt    = gnt_en;
    imem_rvalid = rsp_en && (pend.size() > 0);
    imem_rdata  = imem_rvalid ? mem_word(pend[0].addr) : 32'h0;
  endtask

  task automatic model_clear();
    pend.delete();
    sb.delete();
    exp_pc      = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    imem_gnt    = gnt_en;
    redirect    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    gnt_en = 1'b1; rsp_en = 1'b1;
    instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    model_clear();

    // Reset values and startup latency
    #12;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instr_pc, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    cycle(); chk("boot_req", {31'b0, s_req}, 32'h0);
    cycle(); chk("c2_req", {31'b0, s_req}, 32'h1); chk("c2_addr", s_addr, 32'h0);
    cycle(); chk("c3_valid", {31'b0, s_valid}, 32'h0);
    cycle(); chk("c4_valid", {31'b0, s_valid}, 32'h1); chk("c4_pc", s_pc, 32'h0);
    n_pop = 0;
    repeat (30) cycle();
    chk("stream_flow", {31'b0, n_pop > 10}, 32'h1);

    // Decode stalled: exactly two requests, then back-to-back drain and resume at 8
    instr_ready = 1'b0;
    do_reset();
    n_gnt = 0;
    repeat (10) cycle();
    chk("stall_gnts", n_gnt, 2);
    chk("stall_req_low", {31'b0, s_req}, 32'h0);
    chk("stall_full", {31'b0, s_valid}, 32'h1);
    instr_ready = 1'b1;
    cycle(); chk("drain_pc0", s_pc, 32'h0);
    cycle(); chk("drain_pc4", s_pc, 32'h4);
    chk("resume_req", {31'b0, s_req}, 32'h1); chk("resume_addr", s_addr, 32'h8);

    // Redirect with two requests in flight and no response that cycle
    rsp_en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle();
      ok = (pend.size() == 2) && (sb.size() == 0);
    end
    chk("flush_setup", {31'b0, ok}, 32'h1);
    rsp_en = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    cycle(); chk("redir_req", {31'b0, s_req}, 32'h0);
    redirect = 1'b0;
    cycle(); chk("flush_req1", {31'b0, s_req}, 32'h0);
    cycle(); chk("flush_req2", {31'b0, s_req}, 32'h0);
    cycle(); chk("post_flush_req", {31'b0, s_req}, 32'h1); chk("post_flush_addr", s_addr, 32'h100);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      cycle();
      ok = s_valid;
    end
    chk("first_valid_seen", {31'b0, ok}, 32'h1);
    chk("first_valid_pc", s_pc, 32'h100);

    // Redirect coinciding with the only outstanding response: straight back to RUN
    gnt_en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle();
      ok = (pend.size() == 0) && (sb.size() == 0);
    end
    chk("single_setup", {31'b0, ok}, 32'h1);
    gnt_en = 1'b1;
    cycle();
    gnt_en = 1'b0;
    cycle(); chk("single_req", {31'b0, s_req}, 32'h1);
    chk("single_rvalid", {31'b0, imem_rvalid}, 32'h1);
    redirect = 1'b1; redirect_pc = 32'h203;
    cycle(); chk("redir_rsp_req", {31'b0, s_req}, 32'h0);
    redirect = 1'b0;

    // Grant withheld: address holds at the aligned target
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_req", {31'b0, s_req}, 32'h1);
      chk("hold_addr", s_addr, 32'h200);
    end
    gnt_en = 1'b1;
    repeat (12) cycle();

    // Asynchronous reset with a full queue
    instr_ready = 1'b0;
    repeat (10) cycle();
    chk("pre_rst_full", {31'b0, s_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, instr_valid}, 32'h0);
    chk("arst_instr", instr, NOP);
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_pc", instr_pc, 32'h0);
    model_clear();
    instr_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    cycle(); chk("re_boot_req", {31'b0, s_req}, 32'h0);
    cycle(); chk("re_req", {31'b0, s_req}, 32'h1); chk("re_addr", s_addr, 32'h0);
    repeat (10) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
